id_ex_reg: RTL and testbench

Decode-to-execute pipeline register for the 5-stage pipeline. It sits directly downstream of the register file and captures its two read ports (`rd1`/`rd2`) along with the decoded instruction fields. It applies a same-cycle writeback bypass so operands are never stale, and inserts a bubble on a load-use hazard. It also supports downstream stall and branch/exception flush.

---
 rtl/id_ex_reg_if.sv | 49 ++++
 rtl/id_ex_reg.sv | 116 +++++++++++
 tb/tb_id_ex_reg.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/id_ex_reg_if.sv
// id_ex_if: decode-side inputs and E-stage outputs of the ID/EX pipeline register.
// Port summary: register-file read data, writeback port, decoded fields and
// stall/flush in; registered operands, fields, control, valid and hazard out.
interface id_ex_if #(
  parameter int W  = 32,
  parameter int CW = 8
);
  // Decode stage and register file
  logic [4:0]    pr1;
  logic [4:0]    pr2;
  logic [W-1:0]  rd1;
  logic [W-1:0]  rd2;
  // Writeback port (same values as the register file write port)
  logic [4:0]    wr;
  logic          write;
  logic [W-1:0]  wd;
  // Decoded instruction fields
  logic [W-1:0]  imm_d;
  logic [4:0]    dst_d;
  logic [CW-1:0] ctrl_d;
  logic          valid_d;
  // Pipeline control
  logic          stall;
  logic          flush;
  // E-stage outputs
  logic [W-1:0]  a_e;
  logic [W-1:0]  b_e;
  logic [W-1:0]  imm_e;
  logic [4:0]    pr1_e;
  logic [4:0]    pr2_e;
  logic [4:0]    dst_e;
  logic [CW-1:0] ctrl_e;
  logic          valid_e;
  logic          hazard;

  // Pipeline register side
  modport slave (
    input  pr1, pr2, rd1, rd2, wr, write, wd, imm_d, dst_d, ctrl_d, valid_d,
           stall, flush,
    output a_e, b_e, imm_e, pr1_e, pr2_e, dst_e, ctrl_e, valid_e, hazard
  );

  // Decode / environment side
  modport master (
    output pr1, pr2, rd1, rd2, wr, write, wd, imm_d, dst_d, ctrl_d, valid_d,
           stall, flush,
    input  a_e, b_e, imm_e, pr1_e, pr2_e, dst_e, ctrl_e, valid_e, hazard
  );
endinterface

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with writeback bypass, load-use bubble, stall and flush.
// Latency: decode inputs appear on E outputs one clock later; hazard is combinational.
// Backpressure: stall holds E (held operands still refreshed from writeback); hazard asks upstream to hold.
// Ports: clk, reset (async active-low), bus (id_ex_if.slave: decode in, E stage out).
module id_ex_reg #(
  parameter int W  = 32,
  parameter int CW = 8
) (
  input  logic clk,
  input  logic reset,
  id_ex_if.slave bus
);

  logic [W-1:0]  a_e_q,   a_e_d;
  logic [W-1:0]  b_e_q,   b_e_d;
  logic [W-1:0]  imm_e_q, imm_e_d;
  logic [4:0]    pr1_e_q, pr1_e_d;
  logic [4:0]    pr2_e_q, pr2_e_d;
  logic [4:0]    dst_e_q, dst_e_d;
  logic [CW-1:0] ctrl_e_q, ctrl_e_d;
  logic          valid_e_q, valid_e_d;

  logic [W-1:0]  next_a;
  logic [W-1:0]  next_b;
  logic          hazard;
  logic          wb_live;
  logic          refresh_a;
  logic          refresh_b;

  // Register 0 is hardwired, so a write to it must never be forwarded.
  assign wb_live = bus.write && (bus.wr != 5'd0);

  // Same-cycle writeback bypass: the register file read is still the old value.
  assign next_a = (wb_live && (bus.wr == bus.pr1)) ? bus.wd : bus.rd1;
  assign next_b = (wb_live && (bus.wr == bus.pr2)) ? bus.wd : bus.rd2;

  // A stalled instruction keeps watching writeback so its operands don't go stale.
  assign refresh_a = wb_live && (bus.wr == pr1_e_q);
  assign refresh_b = wb_live && (bus.wr == pr2_e_q);

  // Load in E whose result a valid decode instruction needs: data arrives too late to forward.
  assign hazard = valid_e_q && ctrl_e_q[0] && (dst_e_q != 5'd0) && bus.valid_d &&
                  ((dst_e_q == bus.pr1) || (dst_e_q == bus.pr2));

  always_comb begin
    a_e_d     = a_e_q;
    b_e_d     = b_e_q;
    imm_e_d   = imm_e_q;
    pr1_e_d   = pr1_e_q;
    pr2_e_d   = pr2_e_q;
    dst_e_d   = dst_e_q;
    ctrl_e_d  = ctrl_e_q;
    valid_e_d = valid_e_q;
    if (bus.flush) begin
      a_e_d     = '0;
      b_e_d     = '0;
      imm_e_d   = '0;
      pr1_e_d   = '0;
      pr2_e_d   = '0;
      dst_e_d   = '0;
      ctrl_e_d  = '0;
      valid_e_d = 1'b0;
    end else if (bus.stall) begin
      // Stall outranks the bubble: a pending hazard simply stays asserted.
      if (refresh_a) a_e_d = bus.wd;
      if (refresh_b) b_e_d = bus.wd;
    end else begin
      a_e_d   = next_a;
      b_e_d   = next_b;
      imm_e_d = bus.imm_d;
      pr1_e_d = bus.pr1;
      pr2_e_d = bus.pr2;
      dst_e_d = bus.dst_d;
      if (hazard) begin
        ctrl_e_d  = '0;
        valid_e_d = 1'b0;
      end else begin
        ctrl_e_d  = bus.valid_d ? bus.ctrl_d : '0;
        valid_e_d = bus.valid_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_e_q     <= '0;
      b_e_q     <= '0;
      imm_e_q   <= '0;
      pr1_e_q   <= '0;
      pr2_e_q   <= '0;
      dst_e_q   <= '0;
      ctrl_e_q  <= '0;
      valid_e_q <= 1'b0;
    end else begin
      a_e_q     <= a_e_d;
      b_e_q     <= b_e_d;
      imm_e_q   <= imm_e_d;
      pr1_e_q   <= pr1_e_d;
      pr2_e_q   <= pr2_e_d;
      dst_e_q   <= dst_e_d;
      ctrl_e_q  <= ctrl_e_d;
      valid_e_q <= valid_e_d;
    end
  end

  assign bus.a_e     = a_e_q;
  assign bus.b_e     = b_e_q;
  assign bus.imm_e   = imm_e_q;
  assign bus.pr1_e   = pr1_e_q;
  assign bus.pr2_e   = pr2_e_q;
  assign bus.dst_e   = dst_e_q;
  assign bus.ctrl_e  = ctrl_e_q;
  assign bus.valid_e = valid_e_q;
  assign bus.hazard  = hazard;

endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed bench for the ID/EX pipeline register.
// Latency: checks E outputs 1 ns after the edge that loads them; hazard checked combinationally.
// Backpressure: exercises stall, flush, load-use bubble and held-operand refresh.
module tb_id_ex_reg;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  id_ex_if #(.W(32), .CW(8)) bus ();

  id_ex_reg #(.W(32), .CW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pr1 = 5'd0;  bus.pr2 = 5'd0;
    bus.rd1 = 32'd0; bus.rd2 = 32'd0;
    bus.wr = 5'd0;   bus.write = 1'b0; bus.wd = 32'd0;
    bus.imm_d = 32'd0; bus.dst_d = 5'd0; bus.ctrl_d = 8'd0; bus.valid_d = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    // Put non-zero state in E, then pull reset low mid-cycle.
    bus.pr1 = 5'd3; bus.rd1 = 32'hCAFE; bus.pr2 = 5'd4; bus.rd2 = 32'hBEEF;
    bus.imm_d = 32'h7; bus.dst_d = 5'd9; bus.ctrl_d = 8'h03; bus.valid_d = 1'b1;
    tick();
    bus.pr1 = 5'd9; // decode now depends on the load in E
    #2;
    reset = 1'b0;
    #1;
    n_tests++; if (bus.a_e !== 32'd0) begin n_fail++; $display("FAIL reset_a_e: got %h exp 0", bus.a_e); end
    n_tests++; if (bus.b_e !== 32'd0) begin n_fail++; $display("FAIL reset_b_e: got %h exp 0", bus.b_e); end
    n_tests++; if (bus.imm_e !== 32'd0) begin n_fail++; $display("FAIL reset_imm_e: got %h exp 0", bus.imm_e); end
    n_tests++; if (bus.dst_e !== 5'd0 || bus.pr1_e !== 5'd0 || bus.pr2_e !== 5'd0) begin
      n_fail++; $display("FAIL reset_regnums: got %0d/%0d/%0d exp 0/0/0", bus.pr1_e, bus.pr2_e, bus.dst_e); end
    n_tests++; if (bus.ctrl_e !== 8'd0) begin n_fail++; $display("FAIL reset_ctrl_e: got %h exp 0", bus.ctrl_e); end
    n_tests++; if (bus.valid_e !== 1'b0) begin n_fail++; $display("FAIL reset_valid_e: got %b exp 0", bus.valid_e); end
    n_tests++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %b exp 0", bus.hazard); end
    idle_inputs();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_load();
    bus.pr1 = 5'd5; bus.rd1 = 32'h11; bus.pr2 = 5'd31; bus.rd2 = 32'h22;
    bus.imm_d = 32'hFFFF_FFF0; bus.dst_d = 5'd12; bus.ctrl_d = 8'h02; bus.valid_d = 1'b1;
    tick(); // first edge after reset release
    n_tests++; if (bus.a_e !== 32'h11) begin n_fail++; $display("FAIL load_a_e: got %h exp 11", bus.a_e); end
    n_tests++; if (bus.b_e !== 32'h22) begin n_fail++; $display("FAIL load_b_e: got %h exp 22", bus.b_e); end
    n_tests++; if (bus.ctrl_e !== 8'h02) begin n_fail++; $display("FAIL load_ctrl_e: got %h exp 02", bus.ctrl_e); end
    n_tests++; if (bus.valid_e !== 1'b1) begin n_fail++; $display("FAIL load_valid_e: got %b exp 1", bus.valid_e); end
    n_tests++; if (bus.imm_e !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL load_imm_e: got %h exp fffffff0", bus.imm_e); end
    n_tests++; if (bus.pr1_e !== 5'd5 || bus.pr2_e !== 5'd31 || bus.dst_e !== 5'd12) begin
      n_fail++; $display("FAIL load_regnums: got %0d/%0d/%0d exp 5/31/12", bus.pr1_e, bus.pr2_e, bus.dst_e); end
  endtask

  task automatic test_bypass();
    bus.pr1 = 5'd5; bus.rd1 = 32'hDEAD; bus.pr2 = 5'd6; bus.rd2 = 32'h66;
    bus.write = 1'b1; bus.wr = 5'd5; bus.wd = 32'h1010_1010;
    bus.ctrl_d = 8'h02; bus.valid_d = 1'b1; bus.dst_d = 5'd1;
    tick();
    n_tests++; if (bus.a_e !== 32'h1010_1010) begin n_fail++; $display("FAIL bypass_a_e: got %h exp 10101010", bus.a_e); end
    n_tests++; if (bus.b_e !== 32'h66) begin n_fail++; $display("FAIL bypass_b_untouched: got %h exp 66", bus.b_e); end
    // Bypass on the second port
    bus.pr1 = 5'd2; bus.rd1 = 32'h2; bus.pr2 = 5'd7; bus.rd2 = 32'h77;
    bus.wr = 5'd7; bus.wd = 32'h5A5A_0007;
    tick();
    n_tests++; if (bus.b_e !== 32'h5A5A_0007) begin n_fail++; $display("FAIL bypass_b_e: got %h exp 5a5a0007", bus.b_e); end
    n_tests++; if (bus.a_e !== 32'h2) begin n_fail++; $display("FAIL bypass_a_untouched: got %h exp 2", bus.a_e); end
    // Register 0 is never bypassed
    bus.pr1 = 5'd0; bus.rd1 = 32'd0; bus.wr = 5'd0; bus.wd = 32'hFFFF_FFFF;
    tick();
    n_tests++; if (bus.a_e !== 32'd0) begin n_fail++; $display("FAIL bypass_r0: got %h exp 0", bus.a_e); end
    idle_inputs();
  endtask

  task automatic test_load_use();
    // Load into E: dst 8
    bus.pr1 = 5'd1; bus.pr2 = 5'd2; bus.dst_d = 5'd8; bus.ctrl_d = 8'h03; bus.valid_d = 1'b1;
    tick();
    n_tests++; if (bus.ctrl_e !== 8'h03 || bus.dst_e !== 5'd8) begin
      n_fail++; $display("FAIL lu_setup: got ctrl %h dst %0d exp 03/8", bus.ctrl_e, bus.dst_e); end
    // Dependent instruction on pr2
    bus.pr1 = 5'd3; bus.pr2 = 5'd8; bus.rd1 = 32'h3; bus.rd2 = 32'h8;
    bus.dst_d = 5'd9; bus.ctrl_d = 8'h02;
    #1;
    n_tests++; if (bus.hazard !== 1'b1) begin n_fail++; $display("FAIL lu_hazard: got %b exp 1", bus.hazard); end
    tick();
    n_tests++; if (bus.valid_e !== 1'b0 || bus.ctrl_e !== 8'h00) begin
      n_fail++; $display("FAIL lu_bubble: got valid %b ctrl %h exp 0/00", bus.valid_e, bus.ctrl_e); end
    n_tests++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL lu_hazard_clear: got %b exp 0", bus.hazard); end
    tick();
    n_tests++; if (bus.valid_e !== 1'b1 || bus.ctrl_e !== 8'h02 || bus.dst_e !== 5'd9) begin
      n_fail++; $display("FAIL lu_dependent: got valid %b ctrl %h dst %0d exp 1/02/9", bus.valid_e, bus.ctrl_e, bus.dst_e); end
    // A load targeting r0 never causes a hazard
    bus.pr1 = 5'd1; bus.pr2 = 5'd2; bus.dst_d = 5'd0; bus.ctrl_d = 8'h03;
    tick();
    bus.pr1 = 5'd0; bus.pr2 = 5'd0; bus.dst_d = 5'd4; bus.ctrl_d = 8'h02;
    #1;
    n_tests++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL lu_r0: got %b exp 0", bus.hazard); end
    // Load into E again, then stall with a dependent decode: hazard holds, no bubble
    bus.pr1 = 5'd1; bus.pr2 = 5'd2; bus.dst_d = 5'd8; bus.ctrl_d = 8'h03;
    tick();
    bus.pr1 = 5'd8; bus.pr2 = 5'd0; bus.dst_d = 5'd10; bus.ctrl_d = 8'h02; bus.stall = 1'b1;
    tick();
    n_tests++; if (bus.valid_e !== 1'b1 || bus.ctrl_e !== 8'h03 || bus.dst_e !== 5'd8) begin
      n_fail++; $display("FAIL lu_stall_hold: got valid %b ctrl %h dst %0d exp 1/03/8", bus.valid_e, bus.ctrl_e, bus.dst_e); end
    n_tests++; if (bus.hazard !== 1'b1) begin n_fail++; $display("FAIL lu_stall_hazard: got %b exp 1", bus.hazard); end
    idle_inputs();
    tick();
  endtask

  task automatic test_stall_refresh();
    bus.pr1 = 5'd4; bus.rd1 = 32'h1; bus.pr2 = 5'd6; bus.rd2 = 32'h2;
    bus.imm_d = 32'h55; bus.dst_d = 5'd7; bus.ctrl_d = 8'h02; bus.valid_d = 1'b1;
    tick();
    // Decode changes underneath a stall; E must not follow it
    bus.pr1 = 5'd9; bus.rd1 = 32'h99; bus.pr2 = 5'd10; bus.rd2 = 32'hAA;
    bus.imm_d = 32'h66; bus.dst_d = 5'd11; bus.ctrl_d = 8'h01; bus.stall = 1'b1;
    tick();
    n_tests++; if (bus.a_e !== 32'h1 || bus.pr1_e !== 5'd4) begin
      n_fail++; $display("FAIL stall_c1: got a %h pr1 %0d exp 1/4", bus.a_e, bus.pr1_e); end
    bus.write = 1'b1; bus.wr = 5'd4; bus.wd = 32'hABCD;
    tick();
    n_tests++; if (bus.a_e !== 32'hABCD) begin n_fail++; $display("FAIL stall_refresh_a: got %h exp abcd", bus.a_e); end
    n_tests++; if (bus.b_e !== 32'h2 || bus.imm_e !== 32'h55 || bus.dst_e !== 5'd7 || bus.pr2_e !== 5'd6) begin
      n_fail++; $display("FAIL stall_fields: got b %h imm %h dst %0d pr2 %0d exp 2/55/7/6", bus.b_e, bus.imm_e, bus.dst_e, bus.pr2_e); end
    n_tests++; if (bus.ctrl_e !== 8'h02 || bus.valid_e !== 1'b1) begin
      n_fail++; $display("FAIL stall_ctrl: got ctrl %h valid %b exp 02/1", bus.ctrl_e, bus.valid_e); end
    bus.write = 1'b0;
    tick();
    n_tests++; if (bus.a_e !== 32'hABCD || bus.b_e !== 32'h2) begin
      n_fail++; $display("FAIL stall_c3: got a %h b %h exp abcd/2", bus.a_e, bus.b_e); end
    idle_inputs();
  endtask

  task automatic test_flush();
    bus.pr1 = 5'd1; bus.rd1 = 32'h77; bus.pr2 = 5'd2; bus.rd2 = 32'h88;
    bus.imm_d = 32'h4; bus.dst_d = 5'd8; bus.ctrl_d = 8'h03; bus.valid_d = 1'b1;
    tick();
    bus.flush = 1'b1; bus.stall = 1'b1;
    tick();
    n_tests++; if (bus.valid_e !== 1'b0 || bus.ctrl_e !== 8'h00) begin
      n_fail++; $display("FAIL flush_ctrl: got valid %b ctrl %h exp 0/00", bus.valid_e, bus.ctrl_e); end
    n_tests++; if (bus.a_e !== 32'd0 || bus.b_e !== 32'd0 || bus.imm_e !== 32'd0 || bus.dst_e !== 5'd0) begin
      n_fail++; $display("FAIL flush_data: got a %h b %h imm %h dst %0d exp all 0", bus.a_e, bus.b_e, bus.imm_e, bus.dst_e); end
    idle_inputs();
  endtask

  task automatic test_nonvalid();
    // Load in E first, so a valid decode on pr1=8 would be a hazard
    bus.dst_d = 5'd8; bus.ctrl_d = 8'h03; bus.valid_d = 1'b1;
    tick();
    bus.pr1 = 5'd8; bus.ctrl_d = 8'hFF; bus.valid_d = 1'b0; bus.dst_d = 5'd3;
    #1;
    n_tests++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL nv_hazard: got %b exp 0", bus.hazard); end
    tick();
    n_tests++; if (bus.ctrl_e !== 8'h00 || bus.valid_e !== 1'b0) begin
      n_fail++; $display("FAIL nv_ctrl: got ctrl %h valid %b exp 00/0", bus.ctrl_e, bus.valid_e); end
    idle_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    idle_inputs();
    #1;
    n_tests++; if (bus.valid_e !== 1'b0 || bus.a_e !== 32'd0) begin
      n_fail++; $display("FAIL por: got valid %b a %h exp 0/0", bus.valid_e, bus.a_e); end
    tick();
    reset = 1'b1;
    test_reset();
    test_load();
    test_bypass();
    test_load_use();
    test_stall_refresh();
    test_flush();
    test_nonvalid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
